// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: runs the data-memory request/grant/rvalid
// handshake, aligns load/store lanes and emits a one-cycle writeback record.
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_dst,
    input  logic              ex_reg_write,
    input  logic [3:0]        ex_mem_op,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              addr_exc,
    output logic [ADDR_W-1:0] exc_addr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [3:0]        op_q;
    logic [4:0]        dst_q;
    logic              rw_q;
    logic              kill_q;

    logic              accept, is_mem, is_store, misaligned;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] shifted, load_ext;
    logic [1:0]        a_lo;

    assign a_lo     = ex_alu_out[1:0];
    assign ex_ready = (state == S_IDLE);
    assign accept   = ex_valid & ex_ready & ~flush;

    // Lane steering and alignment for the op being presented by EX.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b0000;
        wdata_d    = '0;
        case (ex_mem_op)
            OP_LB, OP_LBU, OP_SB: begin
                is_mem  = 1'b1;
                be_d    = 4'b0001 << a_lo;
                wdata_d = {4{ex_store_data[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                is_mem     = 1'b1;
                misaligned = a_lo[0];
                be_d       = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{ex_store_data[15:0]}};
            end
            OP_LW, OP_SW: begin
                is_mem     = 1'b1;
                misaligned = |a_lo;
                be_d       = 4'b1111;
                wdata_d    = ex_store_data;
            end
            default: ;
        endcase
        is_store = (ex_mem_op == OP_SB) || (ex_mem_op == OP_SH) || (ex_mem_op == OP_SW);
    end

    assign shifted = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = dmem_rdata;
        case (op_q)
            OP_LB:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU: load_ext = {24'h0, shifted[7:0]};
            OP_LH:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU: load_ext = {16'h0, shifted[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept && is_mem && !misaligned) state_d = S_REQ;
            S_REQ: begin
                if (dmem_gnt)   state_d = we_q ? S_IDLE : S_WAIT;
                else if (flush) state_d = S_IDLE;
            end
            S_WAIT: if (dmem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            op_q         <= '0;
            dst_q        <= '0;
            rw_q         <= 1'b0;
            kill_q       <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dst       <= '0;
            wb_data      <= '0;
            addr_exc     <= 1'b0;
            exc_addr     <= '0;
        end else begin
            state        <= state_d;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            addr_exc     <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (!is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= ex_reg_write;
                        wb_dst       <= ex_dst;
                        wb_data      <= ex_alu_out;
                    end else if (misaligned) begin
                        addr_exc <= 1'b1;
                        exc_addr <= ex_alu_out[ADDR_W-1:0];
                    end else begin
                        addr_q  <= ex_alu_out[ADDR_W-1:0];
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        we_q    <= is_store;
                        op_q    <= ex_mem_op;
                        dst_q   <= ex_dst;
                        rw_q    <= ex_reg_write & ~is_store;
                        kill_q  <= 1'b0;
                    end
                end
                S_REQ: if (dmem_gnt) begin
                    // A flush coinciding with the grant lets the access finish but kills its writeback.
                    kill_q <= flush;
                    if (we_q) begin
                        wb_valid <= ~flush;
                        wb_dst   <= dst_q;
                        wb_data  <= '0;
                    end
                end
                S_WAIT: begin
                    if (flush) kill_q <= 1'b1;
                    if (dmem_rvalid) begin
                        wb_valid     <= ~(kill_q | flush);
                        wb_reg_write <= rw_q & ~(kill_q | flush);
                        wb_dst       <= dst_q;
                        wb_data      <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: steps through the pipeline scenarios
// and checks outputs one time unit after each rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_reg_write, flush;
    logic [31:0] ex_alu_out, ex_store_data;
    logic [4:0]  ex_dst, wb_dst;
    logic [3:0]  ex_mem_op, dmem_be;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data, exc_addr;
    logic        wb_valid, wb_reg_write, addr_exc;

    int compared   = 0;
    int mismatched = 0;

    mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_op(ex_mem_op), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .addr_exc(addr_exc), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] dst, input logic rw);
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_alu_out    = addr;
        ex_store_data = sdata;
        ex_dst        = dst;
        ex_reg_write  = rw;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_alu_out = 0; ex_store_data = 0; ex_dst = 0; ex_reg_write = 0;
        ex_mem_op = 0; flush = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        step();
        step();
        check("rst_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_addr_exc", {31'b0, addr_exc}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        rst = 1'b0;
        step();

        // NONE stream, back to back
        present(4'd0, 32'h10, 32'h0, 5'd3, 1'b1);
        step();
        check("none1_valid", {31'b0, wb_valid}, 32'd1);
        check("none1_data", wb_data, 32'h10);
        check("none1_rw", {31'b0, wb_reg_write}, 32'd1);
        check("none1_dst", {27'b0, wb_dst}, 32'd3);
        ex_alu_out = 32'h20;
        step();
        check("none2_valid", {31'b0, wb_valid}, 32'd1);
        check("none2_data", wb_data, 32'h20);
        ex_alu_out = 32'h30;
        step();
        check("none3_valid", {31'b0, wb_valid}, 32'd1);
        check("none3_data", wb_data, 32'h30);
        check("none3_req", {31'b0, dmem_req}, 32'd0);
        ex_mem_op = 4'd9; ex_alu_out = 32'h99; ex_reg_write = 1'b0;
        step();
        check("op9_data", wb_data, 32'h99);
        check("op9_rw", {31'b0, wb_reg_write}, 32'd0);
        check("op9_req", {31'b0, dmem_req}, 32'd0);
        ex_valid = 1'b0;
        step();
        check("none_idle_valid", {31'b0, wb_valid}, 32'd0);

        // LB at 0x1003, grant after two request cycles, rvalid one cycle later
        present(4'd1, 32'h1003, 32'h0, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        check("lb_req", {31'b0, dmem_req}, 32'd1);
        check("lb_we", {31'b0, dmem_we}, 32'd0);
        check("lb_addr", dmem_addr, 32'h1000);
        check("lb_be", {28'b0, dmem_be}, 32'h8);
        check("lb_ready", {31'b0, ex_ready}, 32'd0);
        step();
        check("lb_req_hold", {31'b0, dmem_req}, 32'd1);
        check("lb_addr_hold", dmem_addr, 32'h1000);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("lb_wait_req", {31'b0, dmem_req}, 32'd0);
        check("lb_wait_ready", {31'b0, ex_ready}, 32'd0);
        check("lb_wait_wb", {31'b0, wb_valid}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF7F;
        step();
        dmem_rvalid = 1'b0;
        check("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_dst", {27'b0, wb_dst}, 32'd5);
        check("lb_wb_rw", {31'b0, wb_reg_write}, 32'd1);
        check("lb_ready_back", {31'b0, ex_ready}, 32'd1);

        // LBU at the same address
        present(4'd2, 32'h1003, 32'h0, 5'd6, 1'b1);
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        check("lbu_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("lbu_wb_data", wb_data, 32'h0000_0080);

        // SH at 0x2002
        present(4'd7, 32'h2002, 32'h1234_ABCD, 5'd7, 1'b0);
        step();
        ex_valid = 1'b0;
        check("sh_req", {31'b0, dmem_req}, 32'd1);
        check("sh_we", {31'b0, dmem_we}, 32'd1);
        check("sh_addr", dmem_addr, 32'h2000);
        check("sh_be", {28'b0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("sh_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        check("sh_ready", {31'b0, ex_ready}, 32'd1);
        check("sh_req_drop", {31'b0, dmem_req}, 32'd0);

        // Misaligned LW, followed immediately by a NONE op
        present(4'd5, 32'h3001, 32'h0, 5'd8, 1'b1);
        step();
        check("mis_exc", {31'b0, addr_exc}, 32'd1);
        check("mis_exc_addr", exc_addr, 32'h3001);
        check("mis_req", {31'b0, dmem_req}, 32'd0);
        check("mis_wb", {31'b0, wb_valid}, 32'd0);
        check("mis_ready", {31'b0, ex_ready}, 32'd1);
        present(4'd0, 32'h44, 32'h0, 5'd9, 1'b1);
        step();
        ex_valid = 1'b0;
        check("post_mis_wb", {31'b0, wb_valid}, 32'd1);
        check("post_mis_data", wb_data, 32'h44);
        check("post_mis_exc", {31'b0, addr_exc}, 32'd0);

        // Flush while the request waits for a grant
        present(4'd5, 32'h4000, 32'h0, 5'd10, 1'b1);
        step();
        ex_valid = 1'b0;
        check("fr_req", {31'b0, dmem_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fr_req_drop", {31'b0, dmem_req}, 32'd0);
        check("fr_wb", {31'b0, wb_valid}, 32'd0);
        check("fr_ready", {31'b0, ex_ready}, 32'd1);
        step();
        check("fr_wb_later", {31'b0, wb_valid}, 32'd0);

        // Flush while waiting for load data
        present(4'd5, 32'h5000, 32'h0, 5'd11, 1'b1);
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fw_still_wait", {31'b0, ex_ready}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 1'b0;
        check("fw_wb", {31'b0, wb_valid}, 32'd0);
        check("fw_ready", {31'b0, ex_ready}, 32'd1);

        // Reset in WAIT, then a stale rvalid
        present(4'd5, 32'h6000, 32'h0, 5'd12, 1'b1);
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("rw_wait", {31'b0, ex_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rw_ready", {31'b0, ex_ready}, 32'd1);
        check("rw_req", {31'b0, dmem_req}, 32'd0);
        check("rw_addr", dmem_addr, 32'h0);
        check("rw_wb_data", wb_data, 32'h0);
        step();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_rvalid = 1'b0;
        check("rw_stale_wb", {31'b0, wb_valid}, 32'd0);
        check("rw_stale_ready", {31'b0, ex_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage load/store unit of the 5-stage MIPS pipeline. Consumes the EX-stage results: ALU output as address or result, store operand, destination register and memory opcode. It performs the data-memory transaction over a request/grant/rvalid handshake and presents a one-cycle writeback record to the WB stage. It back-pressures EX while a memory transaction is outstanding and flags misaligned accesses.

## Interface
Parameters:
- DATA_W, 32, datapath and memory word width (fixed at 32; byte lanes assume 4).
- ADDR_W, 32, byte-address width.

Ports:
- Reset is asynchronous and active-high. One clock.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX presents an instruction this cycle.
- ex_ready  out  1  stage can accept; accept = ex_valid & ex_ready & ~flush.
- ex_alu_out  in  32  effective address (memory ops) or result (others).
- ex_store_data  in  32  rt operand for stores.
- ex_dst  in  5  destination register (already resolved incl. $31 for JAL).
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as NONE.
- flush  in  1  kill the not-yet-granted instruction.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables, lane k = bits [8k+7:8k].
- dmem_wdata  out  32  store data, replicated into lanes.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data.
- wb_valid  out  1  writeback record valid (one-cycle pulse).
- wb_reg_write  out  1  write enable for WB.
- wb_dst  out  5  destination.
- wb_data  out  32  result or extended load data.
- addr_exc  out  1  misaligned access pulse.
- exc_addr  out  32  faulting byte address.

## Operation
- States: IDLE, REQ, WAIT. ex_ready = (state == IDLE).
- IDLE, accept NONE: register result; next cycle wb_valid=1, wb_data=ex_alu_out, wb_reg_write=ex_reg_write; stay IDLE.
- IDLE, accept aligned memory op: latch address/data/op/dst → REQ.
- Alignment: LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0. Misaligned: no request, addr_exc=1 and exc_addr=address for one cycle, wb_valid=0; stay IDLE.
- REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_gnt. On gnt, a store → IDLE, with wb_valid=1 and wb_reg_write=0 next cycle; a load → WAIT.
- WAIT: on dmem_rvalid, extract the lane, sign- or zero-extend, and move to IDLE with the wb record next cycle. rvalid outside WAIT is ignored.
- Byte ops: k=addr[1:0], be=1<<k, wdata={4{byte}}. Half ops: be=addr[1]?1100:0011, wdata={2{half}}. Word: be=1111.
- flush in REQ before or in the same cycle as gnt: the same-cycle gnt is still honoured (the transaction completes), otherwise drop req next cycle → IDLE with no wb. Flush in WAIT: complete the transaction and suppress wb_valid. Flush in IDLE blocks acceptance.

## Timing
- Reset: state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, addr_exc = 0; all data outputs 0. ex_ready=1.
- A reset during REQ or WAIT aborts immediately; a pending rvalid after reset is ignored.
- NONE latency: accept at T → wb_valid at T+1, back-to-back every cycle.
- Load: accept T → req from T+1 → gnt at G → rvalid at R>G → wb_valid at R+1; ex_ready low from T+1 to R.
- Store: wb_valid at G+1; ex_ready high again at G+1.
- wb_valid and addr_exc are always single-cycle pulses, mutually exclusive.

## Test plan
- NONE stream: 3 back-to-back ops with ex_alu_out=0x10,0x20,0x30 → wb_valid on 3 consecutive cycles with matching wb_data; dmem_req never set.
- LB at 0x1003, rdata=0x80FF_FF7F, gnt after 2 cycles, rvalid 1 cycle later → wb_data=0xFFFF_FF80, be=1000; LBU at the same address → 0x0000_0080.
- SH at 0x2002, data=0x1234_ABCD → dmem_addr=0x2000, be=1100, wdata=0xABCD_ABCD; wb_valid with wb_reg_write=0 at G+1.
- LW at 0x3001 → addr_exc pulse, exc_addr=0x3001, no dmem_req, no wb_valid; next op accepted the following cycle.
- Flush while req is held without gnt → req drops the next cycle with no wb. Flush in WAIT → rvalid is absorbed and wb_valid stays 0.
- Assert rst during WAIT → outputs 0 immediately, state IDLE. A stale rvalid afterwards produces no wb.
